// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake and data bundle between fetch, the fetch queue and decode.
// The slave modport is the queue's view; the master modport is the fetch/decode side.
// flush_i is present only when FETCHQ_FLUSH_EN is defined.
interface fetch_queue_if #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueIndexWidth         = 3
);

  // Fetch side
  logic                              enable_i;
  logic [0:instructionWidth-1]       instruction_i;
  logic [0:addressWidth-1]           instructionAddress_i;
  logic                              is64Bit_i;
  logic [0:PidSize-1]                instructionPid_i;
  logic [0:TidSize-1]                instructionTid_i;
  logic                              full_o;
  logic [0:queueIndexWidth]          count_o;

  // Decode side
  logic                              stall_i;
`ifdef FETCHQ_FLUSH_EN
  logic                              flush_i;
`endif
  logic                              enable_o;
  logic [0:instructionWidth-1]       instruction_o;
  logic [0:addressWidth-1]           instructionAddress_o;
  logic                              is64Bit_o;
  logic [0:PidSize-1]                instructionPid_o;
  logic [0:TidSize-1]                instructionTid_o;
  logic [0:instructionCounterWidth-1] instructionMajId_o;

  modport slave (
`ifdef FETCHQ_FLUSH_EN
    input  flush_i,
`endif
    input  enable_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, stall_i,
    output full_o, count_o, enable_o, instruction_o, instructionAddress_o,
           is64Bit_o, instructionPid_o, instructionTid_o, instructionMajId_o
  );

  modport master (
`ifdef FETCHQ_FLUSH_EN
    output flush_i,
`endif
    output enable_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, stall_i,
    input  full_o, count_o, enable_o, instruction_o, instructionAddress_o,
           is64Bit_o, instructionPid_o, instructionTid_o, instructionMajId_o
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Every accepted word is tagged with a monotonically increasing major ID that is
// never rewound. The head entry is presented through registered outputs and held
// while decode stalls. Optional flush support is enabled with FETCHQ_FLUSH_EN.
module fetch_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 8,
  parameter int queueIndexWidth         = 3
) (
  input logic          clock_i,
  input logic          reset_i,
  fetch_queue_if.slave fq
);

  localparam logic [0:queueIndexWidth]           countFull = (queueIndexWidth + 1)'(queueDepth);
  localparam logic [0:queueIndexWidth]           countOne  = (queueIndexWidth + 1)'(1);
  localparam logic [0:queueIndexWidth-1]         ptrOne    = queueIndexWidth'(1);
  localparam logic [0:instructionCounterWidth-1] majOne    = instructionCounterWidth'(1);

  // Entry storage, one array per field
  logic [0:instructionWidth-1]        r_instrMem [queueDepth];
  logic [0:addressWidth-1]            r_addrMem  [queueDepth];
  logic                               r_is64Mem  [queueDepth];
  logic [0:PidSize-1]                 r_pidMem   [queueDepth];
  logic [0:TidSize-1]                 r_tidMem   [queueDepth];
  logic [0:instructionCounterWidth-1] r_majMem   [queueDepth];

  logic [0:queueIndexWidth-1]         r_wrPtr;
  logic [0:queueIndexWidth-1]         r_rdPtr;
  logic [0:queueIndexWidth]           r_count;
  logic [0:instructionCounterWidth-1] r_majCounter;

  // Registered output group
  logic                               r_enableOut;
  logic [0:instructionWidth-1]        r_instrOut;
  logic [0:addressWidth-1]            r_addrOut;
  logic                               r_is64Out;
  logic [0:PidSize-1]                 r_pidOut;
  logic [0:TidSize-1]                 r_tidOut;
  logic [0:instructionCounterWidth-1] r_majOut;

  logic w_full;
  logic w_push;
  logic w_pop;

  // Full and the push/pop decisions all look at the pre-edge count, so a pop in the
  // same cycle never makes room for a push into a full queue. Flush suppresses both.
  assign w_full = (r_count == countFull);
`ifdef FETCHQ_FLUSH_EN
  assign w_push = fq.enable_i && !w_full && !fq.flush_i;
  assign w_pop  = !fq.stall_i && (r_count != '0) && !fq.flush_i;
`else
  assign w_push = fq.enable_i && !w_full;
  assign w_pop  = !fq.stall_i && (r_count != '0);
`endif

  // Write the incoming word and its major ID into the slot at the write pointer
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_instrMem[r_wrPtr] <= fq.instruction_i;
      r_addrMem[r_wrPtr]  <= fq.instructionAddress_i;
      r_is64Mem[r_wrPtr]  <= fq.is64Bit_i;
      r_pidMem[r_wrPtr]   <= fq.instructionPid_i;
      r_tidMem[r_wrPtr]   <= fq.instructionTid_i;
      r_majMem[r_wrPtr]   <= r_majCounter;
    end
  end

  // Pointer, occupancy and major ID bookkeeping; the major ID survives a flush
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_majCounter <= '0;
    end else begin
`ifdef FETCHQ_FLUSH_EN
      if (fq.flush_i) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else
`endif
      begin
        if (w_push) begin
          r_wrPtr      <= r_wrPtr + ptrOne;
          r_majCounter <= r_majCounter + majOne;
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + ptrOne;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + countOne;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - countOne;
        end
      end
    end
  end

  // Present the head entry to decode; hold everything while stalled and keep stale data when empty
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_enableOut <= 1'b0;
      r_instrOut  <= '0;
      r_addrOut   <= '0;
      r_is64Out   <= 1'b0;
      r_pidOut    <= '0;
      r_tidOut    <= '0;
      r_majOut    <= '0;
    end else begin
`ifdef FETCHQ_FLUSH_EN
      if (fq.flush_i) begin
        r_enableOut <= 1'b0;
      end else
`endif
      if (!fq.stall_i) begin
        if (w_pop) begin
          r_enableOut <= 1'b1;
          r_instrOut  <= r_instrMem[r_rdPtr];
          r_addrOut   <= r_addrMem[r_rdPtr];
          r_is64Out   <= r_is64Mem[r_rdPtr];
          r_pidOut    <= r_pidMem[r_rdPtr];
          r_tidOut    <= r_tidMem[r_rdPtr];
          r_majOut    <= r_majMem[r_rdPtr];
        end else begin
          r_enableOut <= 1'b0;
        end
      end
    end
  end

  assign fq.full_o               = w_full;
  assign fq.count_o              = r_count;
  assign fq.enable_o             = r_enableOut;
  assign fq.instruction_o        = r_instrOut;
  assign fq.instructionAddress_o = r_addrOut;
  assign fq.is64Bit_o            = r_is64Out;
  assign fq.instructionPid_o     = r_pidOut;
  assign fq.instructionTid_o     = r_tidOut;
  assign fq.instructionMajId_o   = r_majOut;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based behavioural model. Flush scenarios are built with FETCHQ_FLUSH_EN.
module tb_fetch_queue;

  localparam int addressWidth            = 64;
  localparam int instructionWidth        = 32;
  localparam int PidSize                 = 20;
  localparam int TidSize                 = 16;
  localparam int instructionCounterWidth = 64;
  localparam int queueDepth              = 8;
  localparam int queueIndexWidth         = 3;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [63:0] majId;
  } queueEntry;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int checkCount = 0;
  int failCount  = 0;

  // Behavioural model state
  queueEntry   modelQ[$];
  queueEntry   modelOut;
  logic        modelEnable;
  logic [63:0] modelMaj;

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  fetch_queue_if #(
    .addressWidth(addressWidth), .instructionWidth(instructionWidth),
    .PidSize(PidSize), .TidSize(TidSize),
    .instructionCounterWidth(instructionCounterWidth), .queueIndexWidth(queueIndexWidth)
  ) fqIf ();

  fetch_queue #(
    .addressWidth(addressWidth), .instructionWidth(instructionWidth),
    .PidSize(PidSize), .TidSize(TidSize),
    .instructionCounterWidth(instructionCounterWidth),
    .queueDepth(queueDepth), .queueIndexWidth(queueIndexWidth)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .fq(fqIf)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic queueEntry randEntry();
    queueEntry e;
    e.instr = $urandom;
    e.addr  = {$urandom, $urandom};
    e.is64  = 1'($urandom_range(0, 1));
    e.pid   = 20'($urandom);
    e.tid   = 16'($urandom);
    e.majId = '0;
    return e;
  endfunction

  function automatic queueEntry addrEntry(input logic [63:0] addr);
    queueEntry e;
    e       = randEntry();
    e.addr  = addr;
    e.instr = 32'hA000_0000 + addr[31:0];
    return e;
  endfunction

  task automatic modelReset();
    modelQ.delete();
    modelOut    = '{default: '0};
    modelEnable = 1'b0;
    modelMaj    = '0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge queue occupancy
  task automatic modelStep(input bit en, input bit stall, input bit flush, input queueEntry e);
    queueEntry pushed;
    bit wasFull;
    wasFull = (modelQ.size() == queueDepth);
`ifdef FETCHQ_FLUSH_EN
    if (flush) begin
      modelQ.delete();
      modelEnable = 1'b0;
      return;
    end
`else
    if (flush) $display("[TB] flush request ignored: feature not built");
`endif
    if (!stall) begin
      if (modelQ.size() > 0) begin
        modelOut    = modelQ.pop_front();
        modelEnable = 1'b1;
      end else begin
        modelEnable = 1'b0;
      end
    end
    if (en && !wasFull) begin
      pushed       = e;
      pushed.majId = modelMaj;
      modelQ.push_back(pushed);
      modelMaj     = modelMaj + 64'd1;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".enable"}, 64'(fqIf.enable_o), 64'(modelEnable));
    checkOutput({tag, ".count"},  64'(fqIf.count_o),  64'(modelQ.size()));
    checkOutput({tag, ".full"},   64'(fqIf.full_o),   64'(modelQ.size() == queueDepth));
    checkOutput({tag, ".instr"},  64'(fqIf.instruction_o),        64'(modelOut.instr));
    checkOutput({tag, ".addr"},   64'(fqIf.instructionAddress_o), modelOut.addr);
    checkOutput({tag, ".is64"},   64'(fqIf.is64Bit_o),            64'(modelOut.is64));
    checkOutput({tag, ".pid"},    64'(fqIf.instructionPid_o),     64'(modelOut.pid));
    checkOutput({tag, ".tid"},    64'(fqIf.instructionTid_o),     64'(modelOut.tid));
    checkOutput({tag, ".majId"},  64'(fqIf.instructionMajId_o),   modelOut.majId);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare just after it
  task automatic applyStimulus(input bit en, input bit stall, input bit flush, input queueEntry e, input string tag);
    fqIf.enable_i             = en;
    fqIf.stall_i              = stall;
    fqIf.instruction_i        = e.instr;
    fqIf.instructionAddress_i = e.addr;
    fqIf.is64Bit_i            = e.is64;
    fqIf.instructionPid_i     = e.pid;
    fqIf.instructionTid_i     = e.tid;
`ifdef FETCHQ_FLUSH_EN
    fqIf.flush_i              = flush;
`endif
    @(posedge clock);
    modelStep(en, stall, flush, e);
    #1;
    compareAll(tag);
  endtask

  task automatic idleInputs();
    fqIf.enable_i = 1'b0;
    fqIf.stall_i  = 1'b0;
`ifdef FETCHQ_FLUSH_EN
    fqIf.flush_i  = 1'b0;
`endif
  endtask

  task automatic doReset(input string tag);
    #2;
    idleInputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    modelReset();
    compareAll(tag);
    reset = 1'b0;
  endtask

  initial begin
    queueEntry e;
    idleInputs();
    fqIf.instruction_i        = '0;
    fqIf.instructionAddress_i = '0;
    fqIf.is64Bit_i            = 1'b0;
    fqIf.instructionPid_i     = '0;
    fqIf.instructionTid_i     = '0;
    modelReset();

    doReset("reset");

    // Three pushes at 0x0/0x4/0x8, then drain
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, addrEntry(64'(4 * i)), "push3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, randEntry(), "drain3");
    checkOutput("drain3.countZero", 64'(fqIf.count_o), 64'd0);

    // Fill under stall, overflow push dropped, then drain in order
    doReset("resetFill");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, randEntry(), "fill");
    checkOutput("fill.full", 64'(fqIf.full_o), 64'd1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, randEntry(), "drain8");
    checkOutput("drain8.lastMaj", 64'(fqIf.instructionMajId_o), 64'd7);

    // Full boundary: push with a pop in the same cycle is still rejected
    doReset("resetBoundary");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, randEntry(), "boundFill");
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "boundPushPop");

    // Steady push+pop every cycle
    doReset("resetSteady");
    for (int i = 0; i < 21; i++) applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "steady");

    // Stall while majId 5 is presented
    doReset("resetStall");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "preStall");
    applyStimulus(1'b0, 1'b0, 1'b0, randEntry(), "preStallIdle");
    checkOutput("stall.maj5", 64'(fqIf.instructionMajId_o), 64'd5);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, randEntry(), "stallHold");
    applyStimulus(1'b0, 1'b0, 1'b0, randEntry(), "stallRelease");
    checkOutput("stall.maj6", 64'(fqIf.instructionMajId_o), 64'd6);

    // Asynchronous reset mid-cycle with five words queued
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, randEntry(), "preAsync");
    doReset("resetSync");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, randEntry(), "asyncFill");
    checkOutput("asyncFill.count5", 64'(fqIf.count_o), 64'd5);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll("asyncReset");
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "postResetPush");
    applyStimulus(1'b0, 1'b0, 1'b0, randEntry(), "postResetPop");
    checkOutput("postReset.enable", 64'(fqIf.enable_o), 64'd1);
    checkOutput("postReset.maj0", 64'(fqIf.instructionMajId_o), 64'd0);

`ifdef FETCHQ_FLUSH_EN
    // Flush with a simultaneous push; IDs continue afterwards
    doReset("resetFlush");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, randEntry(), "flushFill");
    applyStimulus(1'b1, 1'b0, 1'b1, randEntry(), "flush");
    checkOutput("flush.count0", 64'(fqIf.count_o), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, randEntry(), "postFlushPush");
    applyStimulus(1'b0, 1'b0, 1'b0, randEntry(), "postFlushPop");
    checkOutput("postFlush.maj4", 64'(fqIf.instructionMajId_o), 64'd4);
`endif

    // Randomized traffic
    doReset("resetRandom");
    for (int i = 0; i < 3000; i++) begin
      e = randEntry();
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 99) < 3, e, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
